// File: rtl/uart_motor_host.sv
// uart_motor_host: initiator side of the motor-control UART link; frames motion
// commands and status polls for a byte transmitter and decodes the 4-byte status reply.
module uart_motor_host #(
    parameter int GAP_CYCLES   = 4095,
    parameter int RESP_TIMEOUT = 262143
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_idx,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_divider,
    input  logic [15:0] cmd_steps,
    input  logic        poll_valid,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        status_valid,
    output logic [9:0]  status_pending,
    output logic [9:0]  status_term,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam logic [17:0] GAP_LOAD = 18'(GAP_CYCLES);
    localparam logic [17:0] TMO_LOAD = 18'(RESP_TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, GAP, WAIT_RESP} state_t;
    state_t state, stateNext;

    logic [47:0] frame;
    logic [2:0]  bytesLeft;
    logic        isPoll;
    logic        busyArmed;
    logic        rxReadyD;
    logic        rxEdge;
    logic        tagOk;
    logic [17:0] gapCnt;
    logic [17:0] toCnt;
    logic [1:0]  replyIdx;
    logic [9:0]  shPend;
    logic [4:0]  shTerm;

    assign rxEdge = rx_ready && !rxReadyD;
    assign tagOk  = (rx_data[7:6] == replyIdx) && !rx_data[5];

    always_comb begin
        stateNext = state;
        cmd_ready = 1'b0;
        tx_start  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if ((cmd_valid && cmd_idx != 4'hF) || (!cmd_valid && poll_valid))
                    stateNext = LOAD;
            end
            LOAD:      stateNext = tx_busy ? LOAD : START;
            START: begin
                tx_start  = 1'b1;
                stateNext = WAIT_BUSY;
            end
            WAIT_BUSY: stateNext = (busyArmed && !tx_busy) ? GAP : WAIT_BUSY;
            GAP:       stateNext = (gapCnt != '0) ? GAP : (bytesLeft != '0) ? LOAD : isPoll ? WAIT_RESP : IDLE;
            WAIT_RESP: stateNext = (toCnt == '0 || (rxEdge && (!tagOk || replyIdx == 2'd3))) ? IDLE : WAIT_RESP;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            frame          <= '0;
            bytesLeft      <= '0;
            isPoll         <= 1'b0;
            busyArmed      <= 1'b0;
            rxReadyD       <= 1'b0;
            gapCnt         <= '0;
            toCnt          <= '0;
            replyIdx       <= '0;
            shPend         <= '0;
            shTerm         <= '0;
            tx_data        <= '0;
            status_valid   <= 1'b0;
            status_pending <= '0;
            status_term    <= '0;
            err            <= 1'b0;
            err_code       <= '0;
        end else begin
            state        <= stateNext;
            rxReadyD     <= rx_ready;
            err          <= 1'b0;
            status_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_idx == 4'hF) begin
                        err      <= 1'b1;
                        err_code <= 2'd1;
                    end else if (cmd_valid) begin
                        frame     <= {cmd_steps, cmd_divider, cmd_dir, 7'h00, 4'h0, cmd_idx};
                        bytesLeft <= 3'd6;
                        isPoll    <= 1'b0;
                    end else if (poll_valid) begin
                        frame     <= {40'h0, 8'h0F};
                        bytesLeft <= 3'd1;
                        isPoll    <= 1'b1;
                    end
                end
                LOAD: begin
                    tx_data <= frame[7:0];
                    if (!tx_busy) begin
                        frame     <= frame >> 8;
                        bytesLeft <= bytesLeft - 3'd1;
                    end
                end
                START: busyArmed <= 1'b0;
                WAIT_BUSY: begin
                    // First cycle after tx_start is skipped: the transmitter may not have raised busy yet
                    busyArmed <= 1'b1;
                    if (busyArmed && !tx_busy)
                        gapCnt <= GAP_LOAD;
                end
                GAP: begin
                    if (gapCnt != '0) begin
                        gapCnt <= gapCnt - 18'd1;
                    end else begin
                        toCnt    <= TMO_LOAD;
                        replyIdx <= '0;
                    end
                end
                WAIT_RESP: begin
                    if (toCnt == '0) begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                    end else begin
                        toCnt <= toCnt - 18'd1;
                        if (rxEdge && !tagOk) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end else if (rxEdge) begin
                            replyIdx <= replyIdx + 2'd1;
                            case (replyIdx)
                                2'd0:    shPend[4:0] <= rx_data[4:0];
                                2'd1:    shPend[9:5] <= rx_data[4:0];
                                2'd2:    shTerm      <= rx_data[4:0];
                                default: begin
                                    status_valid   <= 1'b1;
                                    status_pending <= shPend;
                                    status_term    <= {rx_data[4:0], shTerm};
                                end
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_motor_host.sv
// tb_uart_motor_host: directed bench for uart_motor_host with a busy-counter
// transmitter model; poll replies come from a vector table.
module tb_uart_motor_host;
    localparam int GAP = 4095;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_idx = '0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_divider = '0;
    logic [15:0] cmd_steps = '0;
    logic        poll_valid = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        status_valid;
    logic [9:0]  status_pending;
    logic [9:0]  status_term;
    logic        err;
    logic [1:0]  err_code;

    int busyLen = 10;
    int busyCnt = 0;
    int cyc = 0;
    int errCnt = 0;
    int errCyc = 0;
    int svCnt = 0;
    int passed = 0;
    int total = 0;
    logic [7:0] txLog[$];
    int txCyc[$];

    uart_motor_host #(.GAP_CYCLES(GAP), .RESP_TIMEOUT(TMO)) dut (
        .CLOCK_25(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_idx(cmd_idx), .cmd_dir(cmd_dir), .cmd_divider(cmd_divider), .cmd_steps(cmd_steps),
        .poll_valid(poll_valid), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_ready(rx_ready), .rx_data(rx_data), .status_valid(status_valid),
        .status_pending(status_pending), .status_term(status_term), .err(err), .err_code(err_code)
    );

    always #20 clk = ~clk;

    // Transmitter model: busy for busyLen clocks starting the cycle after tx_start, unaffected by reset
    assign tx_busy = busyCnt != 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        busyCnt <= tx_start ? busyLen : (busyCnt != 0 ? busyCnt - 1 : 0);
    end

    always @(negedge clk) begin
        if (tx_start) begin
            txLog.push_back(tx_data);
            txCyc.push_back(cyc);
        end
        if (err) begin
            errCnt <= errCnt + 1;
            errCyc <= cyc;
        end
        if (status_valid) svCnt <= svCnt + 1;
    end

    typedef struct {
        int              n;
        logic [3:0][7:0] b;
        logic            sv;
        logic [1:0]      code;
        logic [9:0]      pend;
        logic [9:0]      term;
    } pvec_t;
    pvec_t vec[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] txAt(input int i);
        return (txLog.size() > i) ? 32'(txLog[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic int cycAt(input int i);
        return (txCyc.size() > i) ? txCyc[i] : -100000;
    endfunction

    task automatic waitReady(input string tag);
        for (int k = 0; k < 60000 && !cmd_ready; k++) tick();
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    task automatic pollRun(input int vi, input bit request, input string tag);
        int n0, s, e0, v0;
        if (request) begin
            waitReady(tag);
            poll_valid = 1'b1;
            tick();
            poll_valid = 1'b0;
        end
        n0 = txLog.size();
        e0 = errCnt;
        v0 = svCnt;
        for (int k = 0; k < 20000 && txLog.size() == n0; k++) tick();
        check({tag, "_txbyte"}, txAt(n0), 32'h0F);
        s = cycAt(n0);
        while (cyc < s + busyLen + GAP + 6) tick();
        for (int k = 0; k < vec[vi].n; k++) begin
            rx_data = vec[vi].b[k];
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            tick();
            tick();
        end
        if (vec[vi].code == 2'd3) while (cyc < s + busyLen + GAP + TMO + 8) tick();
        else repeat (4) tick();
        check({tag, "_svcount"}, svCnt - v0, 32'(vec[vi].sv));
        check({tag, "_errcount"}, errCnt - e0, (vec[vi].code != 0) ? 1 : 0);
        if (vec[vi].code != 0) check({tag, "_errcode"}, err_code, vec[vi].code);
        if (vec[vi].code == 2'd3) check({tag, "_tmo_cycle"}, errCyc - s, busyLen + GAP + TMO + 4);
        check({tag, "_pending"}, status_pending, vec[vi].pend);
        check({tag, "_term"}, status_term, vec[vi].term);
    endtask

    initial begin
        logic [7:0] encExp[6];
        int n0, n1, e0, v0, readyCyc;
        encExp = '{8'h03, 8'h80, 8'h34, 8'h12, 8'hC8, 8'h00};
        vec[0] = '{4, {8'hC0, 8'h9F, 8'h42, 8'h05}, 1'b1, 2'd0, 10'h045, 10'h01F};
        vec[1] = '{2, {8'h00, 8'h00, 8'h82, 8'h05}, 1'b0, 2'd2, 10'h045, 10'h01F};
        vec[2] = '{1, {8'h00, 8'h00, 8'h00, 8'h25}, 1'b0, 2'd2, 10'h045, 10'h01F};
        vec[3] = '{4, {8'hDF, 8'h80, 8'h5F, 8'h1F}, 1'b1, 2'd0, 10'h3FF, 10'h3E0};
        vec[4] = '{0, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 2'd3, 10'h3FF, 10'h3E0};

        #50;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_status_valid", status_valid, 0);
        check("rst_pending", status_pending, 0);
        check("rst_term", status_term, 0);
        check("rst_err", {err, err_code}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rel_cmd_ready", cmd_ready, 1);

        // Stray byte while idle must vanish
        e0 = errCnt;
        v0 = svCnt;
        rx_data = 8'h55;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (3) tick();
        check("stray_sv", svCnt - v0, 0);
        check("stray_err", errCnt - e0, 0);

        // Command encode and inter-byte gap with a slow transmitter
        busyLen = 2170;
        n0 = txLog.size();
        e0 = errCnt;
        cmd_idx = 4'd3;
        cmd_dir = 1'b1;
        cmd_divider = 16'h1234;
        cmd_steps = 16'h00C8;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("enc_busy_ready", cmd_ready, 0);
        for (int k = 0; k < 60000 && !cmd_ready; k++) tick();
        readyCyc = cyc;
        for (int i = 0; i < 6; i++) check($sformatf("enc_b%0d", i), txAt(n0 + i), 32'(encExp[i]));
        for (int i = 0; i < 5; i++)
            check($sformatf("enc_gap%0d", i), (cycAt(n0 + i + 1) - cycAt(n0 + i)) >= 6268, 1);
        check("enc_ready_cycle", readyCyc - cycAt(n0 + 5), 2170 + GAP + 3);
        check("enc_count", txLog.size() - n0, 6);
        check("enc_err", errCnt - e0, 0);

        // Illegal index: accepted, error, nothing sent
        busyLen = 10;
        n0 = txLog.size();
        e0 = errCnt;
        cmd_idx = 4'hF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("idx15_err", errCnt - e0, 1);
        check("idx15_code", err_code, 1);
        check("idx15_notx", txLog.size() - n0, 0);
        check("idx15_ready", cmd_ready, 1);

        for (int i = 0; i < 5; i++) pollRun(i, 1'b1, $sformatf("poll%0d", i));

        // Command beats a simultaneous poll; reset lands mid-frame
        waitReady("prio");
        n0 = txLog.size();
        cmd_idx = 4'd7;
        cmd_dir = 1'b0;
        cmd_divider = 16'hABCD;
        cmd_steps = 16'h0102;
        cmd_valid = 1'b1;
        poll_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 20000 && txLog.size() < n0 + 3; k++) tick();
        check("prio_b0", txAt(n0), 32'h07);
        check("prio_b1", txAt(n0 + 1), 32'h00);
        check("prio_b2", txAt(n0 + 2), 32'hCD);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_outputs", {tx_start, tx_data, status_valid, err, err_code}, 0);
        check("mid_rst_pending", status_pending, 0);
        check("mid_rst_term", status_term, 0);
        n1 = txLog.size();
        repeat (3) tick();
        check("mid_rst_no_tx", txLog.size() - n1, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        poll_valid = 1'b0;
        pollRun(0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_motor_host.md
Name: uart_motor_host

Overview:
- Initiator end of the motor-control UART protocol. Builds the byte stream a motor-control board consumes and decodes the status reply it returns.
- Encodes 6-byte motion commands (motor index, direction, divider, step count) and the 1-byte status poll (0x0F).
- Collects the 4-byte status reply into pending/terminal vectors.
- Sits between a sequencer (or bench/host FSM) and a byte-level async_transmitter/async_receiver pair on CLOCK_25. Used for board-to-board daisy control and as the bus-functional driver in system sims.

Parameters:
- GAP_CYCLES, 4095: idle clocks enforced after tx_busy falls, before the next tx_start. Must be < 262143.
- RESP_TIMEOUT, 262143: clocks allowed from poll byte completion to the 4th reply byte.

Ports:
- CLOCK_25  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  request to send a motion command
- cmd_ready  out  1  high while idle; command accepted when cmd_valid&&cmd_ready
- cmd_idx  in  4  motor index 0..9; 15 illegal
- cmd_dir  in  1  direction bit
- cmd_divider  in  16  step-rate divider
- cmd_steps  in  16  steps to go
- poll_valid  in  1  request status poll; accepted when poll_valid&&cmd_ready
- tx_start  out  1  one-cycle pulse to the byte transmitter
- tx_data  out  8  byte for transmitter, stable from tx_start until next tx_start
- tx_busy  in  1  transmitter busy
- rx_ready  in  1  receiver data-ready (level or pulse)
- rx_data  in  8  received byte
- status_valid  out  1  one-cycle pulse, reply decoded OK
- status_pending  out  10  pending flags of motors 9..0, held until next status_valid
- status_term  out  10  terminal-switch flags, held until next status_valid
- err  out  1  one-cycle pulse: illegal idx, bad tag, or timeout
- err_code  out  2  1=illegal idx, 2=tag mismatch, 3=timeout; held until next err

Behaviour:
- Reset (async): tx_start=0, tx_data=0, status_valid=0, status_pending=0, status_term=0, err=0, err_code=0, FSM=IDLE, counters=0.
  - A byte already in the external transmitter finishes; no further bytes are issued.
  - After reset release, cmd_ready=1 on the first clock.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, GAP, WAIT_RESP.
- IDLE: cmd_ready=1.
  - If both cmd_valid and poll_valid: command wins, poll is not accepted.
  - cmd_idx==15: accepted; err=1 pulse, err_code=1; no bytes sent; stay IDLE.
  - Otherwise, legal command: latch a 6-byte frame.
    - b0 = {4'h0, idx}
    - b1 = {dir, 7'h0}
    - b2 = divider[7:0]
    - b3 = divider[15:8]
    - b4 = steps[7:0]
    - b5 = steps[15:8]
    - byte count = 6; go to LOAD.
  - Poll: frame = {0x0F}, count = 1; go to LOAD.
- LOAD: put the next frame byte on tx_data. If tx_busy=0, go to START.
- START: tx_start=1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY: ignore tx_busy on the first cycle, then wait for tx_busy=0. Load the gap counter with GAP_CYCLES and go to GAP.
- GAP: count down to 0, then:
  - more bytes remain -> LOAD;
  - poll frame -> WAIT_RESP, timeout counter = RESP_TIMEOUT, reply index = 0;
  - command frame -> IDLE.
- Minimum spacing between successive tx_start pulses = byte time + GAP_CYCLES + 3 clocks.
- RX: a byte is taken only on a rising edge of rx_ready (rx_ready registered once; edge = rx_ready && !rx_ready_d). Bytes arriving outside WAIT_RESP are discarded silently.
- WAIT_RESP: expect 4 bytes in order. For reply index k, rx_data[7:6] must equal k and rx_data[5] must be 0.
  - k=0 -> pending[4:0]
  - k=1 -> pending[9:5]
  - k=2 -> term[4:0]
  - k=3 -> term[9:5]
  - Shadow registers are used; outputs update only on success.
  - After the 4th good byte: status_valid pulse, outputs update the same cycle, go to IDLE.
  - Tag/bit5 mismatch: err pulse, err_code=2, outputs unchanged, go to IDLE.
  - Timeout counter reaches 0 before the 4th byte: err pulse, err_code=3, go to IDLE. An edge arriving on the expiry cycle is ignored.
- Simultaneous rx edge and timeout expiry: timeout wins.
- No back-to-back poll is accepted while in WAIT_RESP; cmd_ready=0 throughout.

Test Plan:
- Command encode: cmd idx=3, dir=1, divider=0x1234, steps=0x00C8 -> tx bytes 0x03,0x80,0x34,0x12,0xC8,0x00 in order; returns to IDLE with no err.
- Gap timing: model transmitter busy for 2170 clocks, GAP_CYCLES=4095 -> successive tx_start rising edges are ≥6268 clocks apart; cmd_ready=0 until the last gap ends.
- Poll decode: poll -> tx 0x0F; reply 0x05,0x42,0x9F,0xC0 -> status_valid pulse once, status_pending=0x045, status_term=0x01F.
- Error paths:
  - reply 0x05,0x82 -> err_code=2, outputs unchanged;
  - no reply -> err_code=3 exactly RESP_TIMEOUT+1 clocks after entering WAIT_RESP;
  - cmd_idx=15 -> err_code=1, no tx_start.
- Priority/discard: cmd_valid and poll_valid both high -> command frame sent first, poll accepted afterward. Stray rx byte 0x55 while IDLE -> no status_valid, no err.
- Reset mid-frame: assert reset after the 3rd tx_start of a command -> tx_start stays 0, all outputs 0 asynchronously. After release, a new poll is sent correctly starting with 0x0F.
